// File: rtl/reg_wb_queue_if.sv
// rtl/reg_wb_queue_if.sv - producer, register-file and forwarding signals of the writeback queue
// master drives requests and lookups; slave is the queue itself.
interface reg_wb_queue_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_dest;
  logic [DATA_W-1:0] ld_data;
  logic              stall;
  logic              RegWrite;
  logic [ADDR_W-1:0] destination;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] fwd_a_addr;
  logic              fwd_a_hit;
  logic [DATA_W-1:0] fwd_a_data;
  logic [ADDR_W-1:0] fwd_b_addr;
  logic              fwd_b_hit;
  logic [DATA_W-1:0] fwd_b_data;
  logic [CNT_W-1:0]  count;
  logic              err_sticky;

  modport master (
    output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
    output fwd_a_addr, fwd_b_addr,
    input  stall, RegWrite, destination, write_data,
    input  fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data, count, err_sticky
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
    input  fwd_a_addr, fwd_b_addr,
    output stall, RegWrite, destination, write_data,
    output fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data, count, err_sticky
  );
endinterface

// File: rtl/reg_wb_queue.sv
// rtl/reg_wb_queue.sv - in-order register writeback FIFO with operand forwarding
// Load and ALU writes are queued (load first) and drained one per cycle into the register file.
module reg_wb_queue #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 12,
  parameter int DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_wb_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_dest [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              out_valid;
  logic [ADDR_W-1:0] out_dest;
  logic [DATA_W-1:0] out_data;
  logic              err;

  logic              ld_legal;
  logic              alu_legal;
  logic              pop;
  logic              ld_push;
  logic              alu_push;
  logic              drop;
  logic [CNT_W-1:0]  room;
  logic [CNT_W-1:0]  cnt_next;
  logic [PTR_W-1:0]  alu_slot;

  // Room counts the slot freed by this cycle's pop, so full-with-pop still accepts one entry.
  always_comb begin
    ld_legal  = bus.ld_valid  && (int'(bus.ld_dest)  < NUM_REGS);
    alu_legal = bus.alu_valid && (int'(bus.alu_dest) < NUM_REGS);
    pop       = (cnt != '0);
    room      = CNT_W'(DEPTH) - cnt + CNT_W'(pop);
    ld_push   = ld_legal && (room != '0);
    alu_push  = alu_legal && (room > CNT_W'(ld_push));
    drop      = (bus.ld_valid && !ld_push) || (bus.alu_valid && !alu_push);
    alu_slot  = wr_ptr + PTR_W'(ld_push);
    cnt_next  = cnt + CNT_W'(ld_push) + CNT_W'(alu_push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_dest  <= '0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      if (ld_push) begin
        mem_dest[wr_ptr] <= bus.ld_dest;
        mem_data[wr_ptr] <= bus.ld_data;
      end
      if (alu_push) begin
        mem_dest[alu_slot] <= bus.alu_dest;
        mem_data[alu_slot] <= bus.alu_data;
      end
      wr_ptr    <= wr_ptr + PTR_W'(ld_push) + PTR_W'(alu_push);
      out_valid <= pop;
      if (pop) begin
        out_dest <= mem_dest[rd_ptr];
        out_data <= mem_data[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt_next;
      if (drop) begin
        err <= 1'b1;
      end
    end
  end

  // Scan oldest to youngest so the last matching source wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx            = '0;
    bus.fwd_a_hit  = 1'b0;
    bus.fwd_a_data = '0;
    bus.fwd_b_hit  = 1'b0;
    bus.fwd_b_data = '0;
    if (out_valid && out_dest == bus.fwd_a_addr) begin
      bus.fwd_a_hit  = 1'b1;
      bus.fwd_a_data = out_data;
    end
    if (out_valid && out_dest == bus.fwd_b_addr) begin
      bus.fwd_b_hit  = 1'b1;
      bus.fwd_b_data = out_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < cnt && mem_dest[idx] == bus.fwd_a_addr) begin
        bus.fwd_a_hit  = 1'b1;
        bus.fwd_a_data = mem_data[idx];
      end
      if (CNT_W'(i) < cnt && mem_dest[idx] == bus.fwd_b_addr) begin
        bus.fwd_b_hit  = 1'b1;
        bus.fwd_b_data = mem_data[idx];
      end
    end
  end

  assign bus.stall       = (cnt >= CNT_W'(DEPTH - 1));
  assign bus.count       = cnt;
  assign bus.RegWrite    = out_valid;
  assign bus.destination = out_dest;
  assign bus.write_data  = out_data;
  assign bus.err_sticky  = err;
endmodule

// File: tb/tb_reg_wb_queue.sv
// tb/tb_reg_wb_queue.sv - self-checking bench for reg_wb_queue
// Hand-computed vector table plus a queue-based reference model of the writeback FIFO.
module tb_reg_wb_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  reg_wb_queue_if #(.DATA_W(8), .ADDR_W(4), .DEPTH(4)) bus ();

  reg_wb_queue #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(12), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] dest;
    logic [7:0] data;
  } ent_t;

  typedef struct {
    logic       lv;
    logic [3:0] ld;
    logic [7:0] ldd;
    logic       av;
    logic [3:0] ad;
    logic [7:0] add;
    logic [3:0] fa;
    logic       e_rw;
    logic [3:0] e_dest;
    logic [7:0] e_data;
    int         e_cnt;
    logic       e_hit;
    logic [7:0] e_fdata;
    logic       e_err;
  } vec_t;

  ent_t mq[$];
  ent_t m_out;
  logic m_rw;
  logic m_err;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_fwd(input logic [3:0] a, output logic hit, output logic [7:0] d);
    hit = 1'b0;
    d   = 8'h00;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].dest == a) begin
        hit = 1'b1;
        d   = mq[i].data;
        break;
      end
    end
    if (!hit && m_rw && m_out.dest == a) begin
      hit = 1'b1;
      d   = m_out.data;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.ld_valid = 1'b0;
    bus.alu_valid = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();
    m_rw  = 1'b0;
    m_err = 1'b0;
    m_out = '0;
    check("rst_regwrite", bus.RegWrite, 0);
    check("rst_dest", bus.destination, 0);
    check("rst_data", bus.write_data, 0);
    check("rst_count", bus.count, 0);
    check("rst_err", bus.err_sticky, 0);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic lv, input logic [3:0] ld, input logic [7:0] ldd,
                      input logic av, input logic [3:0] ad, input logic [7:0] add,
                      input logic [3:0] fa);
    int   pre;
    int   occ;
    logic h;
    logic [7:0] d;
    bus.ld_valid   = lv;
    bus.ld_dest    = ld;
    bus.ld_data    = ldd;
    bus.alu_valid  = av;
    bus.alu_dest   = ad;
    bus.alu_data   = add;
    bus.fwd_a_addr = fa;
    bus.fwd_b_addr = 4'($urandom_range(0, 15));
    pre  = mq.size();
    m_rw = (pre > 0);
    occ  = pre - (m_rw ? 1 : 0);
    if (lv) begin
      if (ld < 4'd12 && occ < 4) begin
        mq.push_back('{dest: ld, data: ldd});
        occ++;
      end else m_err = 1'b1;
    end
    if (av) begin
      if (ad < 4'd12 && occ < 4) begin
        mq.push_back('{dest: ad, data: add});
        occ++;
      end else m_err = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.ld_valid  = 1'b0;
    bus.alu_valid = 1'b0;
    check("regwrite", bus.RegWrite, m_rw);
    if (m_rw) begin
      m_out = mq.pop_front();
      check("commit_dest", bus.destination, m_out.dest);
      check("commit_data", bus.write_data, m_out.data);
    end
    check("count", bus.count, mq.size());
    check("stall", bus.stall, mq.size() >= 3);
    check("err_sticky", bus.err_sticky, m_err);
    model_fwd(bus.fwd_a_addr, h, d);
    check("fwd_a_hit", bus.fwd_a_hit, h);
    check("fwd_a_data", bus.fwd_a_data, d);
    model_fwd(bus.fwd_b_addr, h, d);
    check("fwd_b_hit", bus.fwd_b_hit, h);
    check("fwd_b_data", bus.fwd_b_data, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 4'($urandom_range(0, 11)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int peak;
    bus.ld_valid = 0; bus.ld_dest = 0; bus.ld_data = 0;
    bus.alu_valid = 0; bus.alu_dest = 0; bus.alu_data = 0;
    bus.fwd_a_addr = 0; bus.fwd_b_addr = 0;
    m_rw = 0; m_err = 0; m_out = '0;

    //        lv ld  ldd    av ad  add    fa  rw dest data   cnt hit fdata  err
    tbl[0] = '{0, 0, 8'h00, 1, 3, 8'h5A, 3,  0, 0, 8'h00, 1, 1, 8'h5A, 0};
    tbl[1] = '{0, 0, 8'h00, 0, 0, 8'h00, 3,  1, 3, 8'h5A, 0, 1, 8'h5A, 0};
    tbl[2] = '{0, 0, 8'h00, 0, 0, 8'h00, 3,  0, 3, 8'h5A, 0, 0, 8'h00, 0};
    tbl[3] = '{1, 2, 8'h11, 1, 2, 8'h22, 2,  0, 3, 8'h5A, 2, 1, 8'h22, 0};
    tbl[4] = '{0, 0, 8'h00, 0, 0, 8'h00, 2,  1, 2, 8'h11, 1, 1, 8'h22, 0};
    tbl[5] = '{0, 0, 8'h00, 0, 0, 8'h00, 2,  1, 2, 8'h22, 0, 1, 8'h22, 0};
    tbl[6] = '{0, 0, 8'h00, 0, 0, 8'h00, 2,  0, 2, 8'h22, 0, 0, 8'h00, 0};
    tbl[7] = '{0, 0, 8'h00, 1, 12, 8'hFF, 12, 0, 2, 8'h22, 0, 0, 8'h00, 1};
    tbl[8] = '{0, 0, 8'h00, 0, 0, 8'h00, 12, 0, 2, 8'h22, 0, 0, 8'h00, 1};

    @(posedge clk);
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].lv, tbl[i].ld, tbl[i].ldd, tbl[i].av, tbl[i].ad, tbl[i].add, tbl[i].fa);
      check($sformatf("v%0d_regwrite", i), bus.RegWrite, tbl[i].e_rw);
      check($sformatf("v%0d_dest", i), bus.destination, tbl[i].e_dest);
      check($sformatf("v%0d_data", i), bus.write_data, tbl[i].e_data);
      check($sformatf("v%0d_count", i), bus.count, tbl[i].e_cnt);
      check($sformatf("v%0d_fwd_hit", i), bus.fwd_a_hit, tbl[i].e_hit);
      check($sformatf("v%0d_fwd_data", i), bus.fwd_a_data, tbl[i].e_fdata);
      check($sformatf("v%0d_err", i), bus.err_sticky, tbl[i].e_err);
    end

    // Back-to-back ALU writes regardless of stall.
    reset_dut();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 4'(i + 4), 8'($urandom), 4'(i + 4));
    idle(3);
    check("alu_burst_drained", mq.size(), 0);
    check("alu_burst_err", bus.err_sticky, 0);

    // Both producers every cycle: reaches full, stalls, then overflows.
    reset_dut();
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 4'($urandom_range(0, 11)), 8'($urandom), 1, 4'($urandom_range(0, 11)), 8'($urandom),
           4'($urandom_range(0, 11)));
      if (int'(bus.count) > peak) peak = int'(bus.count);
    end
    check("dual_peak", peak, 4);
    check("dual_err", bus.err_sticky, 1);
    idle(6);
    check("dual_drained", mq.size(), 0);

    // Reset while entries are queued: nothing may commit afterwards.
    reset_dut();
    step(1, 1, 8'hA1, 1, 5, 8'hA5, 1);
    step(1, 6, 8'hA6, 1, 7, 8'hA7, 6);
    check("fill_count", bus.count, 3);
    reset_dut();
    idle(4);
    check("post_reset_empty", bus.count, 0);

    // Random mixed traffic with occasional illegal destinations.
    reset_dut();
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 12)), 8'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 12)), 8'($urandom),
           4'($urandom_range(0, 11)));
    end
    idle(6);
    check("random_drained", mq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
